// File: rtl/mul_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_pkg
//  Description : Shared types and constants for the multiplier-sharing
//                controller: FSM state encoding, datapath widths and the
//                default watchdog limit.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_share_pkg;

    localparam int c_operand_w          = 32;
    localparam int c_result_w           = 64;
    localparam int c_timeout_cyc_default = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Starting at i_ptr and
//                wrapping around, selects the first asserted request and
//                returns it both one-hot and encoded.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_id
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Scan from the pointer with wrap-around; the first set request wins.
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((int'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_ctrl
//  Description : Shares one sequential 32x32 signed multiplier among N_REQ
//                requesters. Round-robin grant, operand latch, start pulse,
//                wait for done, capture result, clear pulse, tagged response.
//                Optional watchdog on the WAIT state: MUL_SHARE_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = c_timeout_cyc_default
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [c_operand_w*N_REQ-1:0] req_multiplicand,
    input  logic [c_operand_w*N_REQ-1:0] req_multiplier,
    output logic [N_REQ-1:0]             gnt,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [c_result_w-1:0]        rsp_result,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [c_operand_w-1:0]       m_multiplicand,
    output logic [c_operand_w-1:0]       m_multiplier,
    output logic                         m_op_start,
    output logic                         m_op_clear,
    input  logic                         m_op_done,
    input  logic [c_result_w-1:0]        m_result
);

    if (N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ) || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mul_share_ctrl: illegal parameter combination");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_ptr;
    logic [ID_W-1:0]         r_id;
    logic [ID_W-1:0]         r_rsp_id;
    logic [c_result_w-1:0]   r_rsp_result;
    logic [c_operand_w-1:0]  r_m_a;
    logic [c_operand_w-1:0]  r_m_b;
    logic [N_REQ-1:0]        w_grant;
    logic [ID_W-1:0]         w_win_id;
    logic [ID_W-1:0]         w_ptr_nxt;
    logic [c_operand_w-1:0]  w_sel_a;
    logic [c_operand_w-1:0]  w_sel_b;
    logic                    w_grant_fire;
    logic                    w_wait_exit;
    logic                    w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_win_id)
    );

    assign w_grant_fire = (r_state == IDLE) && (|req);
    assign w_wait_exit  = (r_state == WAIT) && (m_op_done || w_timeout);
    assign w_ptr_nxt    = (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + 1'b1;

    // Select the winner's operand slices for latching in the grant cycle.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_multiplicand[i*c_operand_w +: c_operand_w];
                w_sel_b = req_multiplier[i*c_operand_w +: c_operand_w];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a done seen outside WAIT is deliberately ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_nxt = START;
            START:   w_state_nxt = WAIT;
            WAIT:    if (m_op_done || w_timeout) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch at grant, pointer advance, and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_m_a        <= '0;
            r_m_b        <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else begin
            if (w_grant_fire) begin
                r_m_a <= w_sel_a;
                r_m_b <= w_sel_b;
                r_id  <= w_win_id;
                r_ptr <= w_ptr_nxt;
            end
            if (w_wait_exit) begin
                r_rsp_id     <= r_id;
                // A watchdog exit has no valid product, so report zero.
                r_rsp_result <= m_op_done ? m_result : '0;
            end
        end
    end

`ifdef MUL_SHARE_TIMEOUT_EN
    localparam int c_wdog_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_wdog_w-1:0] r_wdog;
    logic                r_rsp_err;

    assign w_timeout = (r_state == WAIT) && (r_wdog == c_wdog_w'(TIMEOUT_CYC - 1));

    // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (reset || (r_state != WAIT)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Error flag follows the response it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_err <= 1'b0;
        end else if (w_wait_exit) begin
            r_rsp_err <= !m_op_done;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign gnt            = (w_grant_fire && !reset) ? w_grant : '0;
    assign m_op_start     = (r_state == START);
    assign m_op_clear     = (r_state == CLEAR);
    assign rsp_valid      = (r_state == CLEAR);
    assign busy           = (r_state != IDLE);
    assign rsp_id         = r_rsp_id;
    assign rsp_result     = r_rsp_result;
    assign m_multiplicand = r_m_a;
    assign m_multiplier   = r_m_b;

endmodule
`default_nettype wire
